// File: rtl/psram_responder_if.sv
// Signal bundle between a PSRAM controller, the responder model and its backing memory.
// The master modport is the controller/memory side; the slave modport is the responder.
interface psram_responder_if;
    logic        i_psram_csn;
    logic        i_psram_sclk;
    logic [3:0]  i_psram_dq;
    logic [3:0]  o_psram_dq;
    logic        o_psram_oe;
    logic [23:0] o_mem_addr;
    logic        o_mem_we;
    logic        o_mem_re;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic        o_quad;
    logic        o_active;

    modport slave (
        input  i_psram_csn, i_psram_sclk, i_psram_dq, i_mem_rdata,
        output o_psram_dq, o_psram_oe, o_mem_addr, o_mem_we, o_mem_re,
               o_mem_wdata, o_quad, o_active
    );

    modport master (
        output i_psram_csn, i_psram_sclk, i_psram_dq, i_mem_rdata,
        input  o_psram_dq, o_psram_oe, o_mem_addr, o_mem_we, o_mem_re,
               o_mem_wdata, o_quad, o_active
    );
endinterface

// File: rtl/psram_responder.sv
// PSRAM device model: decodes SPI/QPI commands from an oversampled serial bus and
// turns quad read/write bursts into byte strobes on a simple backing-memory port.
module psram_responder #(
    parameter int WAIT_CYCLES = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    psram_responder_if.slave bus
);
    localparam int WAIT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    typedef enum logic [3:0] {
        SPI_IDLE,
        SPI_CMD,
        Q_IDLE,
        Q_CMD,
        Q_ADDR,
        Q_WAIT,
        Q_RDATA,
        Q_WDATA,
        IGNORE
    } state_t;

    logic              r_sclk, r_sclkPrev, r_csn, r_csnPrev;
    logic [3:0]        r_dq;
    logic              w_sclkRise, w_sclkFall, w_csnRise, w_csnFall;

    state_t            r_state, w_stateNext;
    logic              r_quad, w_quadNext;
    logic [7:0]        r_shift, w_shiftNext;
    logic [3:0]        r_cnt, w_cntNext;
    logic              r_isWrite, w_isWriteNext;
    logic [23:0]       r_addr, w_addrNext;
    logic [WAIT_W-1:0] r_waitCnt, w_waitNext;
    logic [7:0]        r_rdBuf, w_rdBufNext;
    logic              r_rdPend, w_rdPendNext;
    logic [3:0]        r_lowNib, w_lowNibNext;
    logic              r_lowDue, w_lowDueNext;
    logic [3:0]        r_dqOut, w_dqOutNext;
    logic              r_oe, w_oeNext;
    logic              r_we, w_weNext;
    logic              r_re, w_reNext;
    logic [7:0]        r_wdata, w_wdataNext;
    logic [3:0]        r_wrHigh, w_wrHighNext;
    logic              r_wrHalf, w_wrHalfNext;

    // csn resets low so a controller already holding csn low at reset release
    // does not look like a fresh falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk     <= 1'b0;
            r_sclkPrev <= 1'b0;
            r_csn      <= 1'b0;
            r_csnPrev  <= 1'b0;
            r_dq       <= 4'h0;
        end else begin
            r_sclk     <= bus.i_psram_sclk;
            r_sclkPrev <= r_sclk;
            r_csn      <= bus.i_psram_csn;
            r_csnPrev  <= r_csn;
            r_dq       <= bus.i_psram_dq;
        end
    end

    assign w_sclkRise = ~r_sclkPrev & r_sclk;
    assign w_sclkFall = r_sclkPrev & ~r_sclk;
    assign w_csnRise  = ~r_csnPrev & r_csn;
    assign w_csnFall  = r_csnPrev & ~r_csn;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= SPI_IDLE;
            r_quad    <= 1'b0;
            r_shift   <= 8'h00;
            r_cnt     <= 4'h0;
            r_isWrite <= 1'b0;
            r_addr    <= 24'h000000;
            r_waitCnt <= '0;
            r_rdBuf   <= 8'h00;
            r_rdPend  <= 1'b0;
            r_lowNib  <= 4'h0;
            r_lowDue  <= 1'b0;
            r_dqOut   <= 4'h0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_wdata   <= 8'h00;
            r_wrHigh  <= 4'h0;
            r_wrHalf  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_quad    <= w_quadNext;
            r_shift   <= w_shiftNext;
            r_cnt     <= w_cntNext;
            r_isWrite <= w_isWriteNext;
            r_addr    <= w_addrNext;
            r_waitCnt <= w_waitNext;
            r_rdBuf   <= w_rdBufNext;
            r_rdPend  <= w_rdPendNext;
            r_lowNib  <= w_lowNibNext;
            r_lowDue  <= w_lowDueNext;
            r_dqOut   <= w_dqOutNext;
            r_oe      <= w_oeNext;
            r_we      <= w_weNext;
            r_re      <= w_reNext;
            r_wdata   <= w_wdataNext;
            r_wrHigh  <= w_wrHighNext;
            r_wrHalf  <= w_wrHalfNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_quadNext    = r_quad;
        w_shiftNext   = r_shift;
        w_cntNext     = r_cnt;
        w_isWriteNext = r_isWrite;
        w_addrNext    = r_addr;
        w_waitNext    = r_waitCnt;
        w_rdBufNext   = r_rdBuf;
        w_rdPendNext  = r_re;
        w_lowNibNext  = r_lowNib;
        w_lowDueNext  = r_lowDue;
        w_dqOutNext   = r_dqOut;
        w_oeNext      = r_oe;
        w_weNext      = 1'b0;
        w_reNext      = 1'b0;
        w_wdataNext   = r_wdata;
        w_wrHighNext  = r_wrHigh;
        w_wrHalfNext  = r_wrHalf;

        // Memory returns data one cycle after the read strobe; a write strobe
        // goes out with the current address, which advances right after.
        if (r_rdPend) begin
            w_rdBufNext = bus.i_mem_rdata;
        end
        if (r_we) begin
            w_addrNext = r_addr + 24'd1;
        end

        if (w_csnRise) begin
            w_oeNext     = 1'b0;
            w_dqOutNext  = 4'h0;
            w_wrHalfNext = 1'b0;
            w_stateNext  = r_quad ? Q_IDLE : SPI_IDLE;
        end else begin
            case (r_state)
                SPI_IDLE: begin
                    if (w_csnFall) begin
                        w_stateNext = SPI_CMD;
                        w_cntNext   = 4'h0;
                    end
                end
                Q_IDLE: begin
                    if (w_csnFall) begin
                        w_stateNext = Q_CMD;
                        w_cntNext   = 4'h0;
                    end
                end
                SPI_CMD: begin
                    if (w_sclkRise) begin
                        w_shiftNext = {r_shift[6:0], r_dq[0]};
                        w_cntNext   = r_cnt + 4'd1;
                        if (r_cnt == 4'd7) begin
                            if ({r_shift[6:0], r_dq[0]} == 8'h35) begin
                                w_quadNext = 1'b1;
                            end
                            w_stateNext = IGNORE;
                        end
                    end
                end
                Q_CMD: begin
                    if (w_sclkRise) begin
                        w_shiftNext = {r_shift[3:0], r_dq};
                        w_cntNext   = r_cnt + 4'd1;
                        if (r_cnt == 4'd1) begin
                            w_cntNext = 4'h0;
                            case ({r_shift[3:0], r_dq})
                                8'hEB: begin
                                    w_stateNext   = Q_ADDR;
                                    w_isWriteNext = 1'b0;
                                end
                                8'h38: begin
                                    w_stateNext   = Q_ADDR;
                                    w_isWriteNext = 1'b1;
                                end
                                8'hF5: begin
                                    w_quadNext  = 1'b0;
                                    w_stateNext = IGNORE;
                                end
                                default: w_stateNext = IGNORE;
                            endcase
                        end
                    end
                end
                Q_ADDR: begin
                    if (w_sclkRise) begin
                        w_addrNext = {r_addr[19:0], r_dq};
                        w_cntNext  = r_cnt + 4'd1;
                        if (r_cnt == 4'd5) begin
                            if (r_isWrite) begin
                                w_stateNext  = Q_WDATA;
                                w_wrHalfNext = 1'b0;
                            end else begin
                                w_stateNext = Q_WAIT;
                                w_reNext    = 1'b1;
                                w_waitNext  = '0;
                            end
                        end
                    end
                end
                Q_WAIT: begin
                    if (w_sclkRise && (r_waitCnt != WAIT_LAST)) begin
                        w_waitNext = r_waitCnt + 1'b1;
                    end else if (w_sclkFall && (r_waitCnt == WAIT_LAST)) begin
                        w_dqOutNext  = r_rdBuf[7:4];
                        w_lowNibNext = r_rdBuf[3:0];
                        w_lowDueNext = 1'b1;
                        w_oeNext     = 1'b1;
                        w_addrNext   = r_addr + 24'd1;
                        w_reNext     = 1'b1;
                        w_stateNext  = Q_RDATA;
                    end
                end
                Q_RDATA: begin
                    // Low nibble is saved aside so the prefetch may overwrite the buffer.
                    if (w_sclkFall) begin
                        if (r_lowDue) begin
                            w_dqOutNext  = r_lowNib;
                            w_lowDueNext = 1'b0;
                        end else begin
                            w_dqOutNext  = r_rdBuf[7:4];
                            w_lowNibNext = r_rdBuf[3:0];
                            w_lowDueNext = 1'b1;
                            w_addrNext   = r_addr + 24'd1;
                            w_reNext     = 1'b1;
                        end
                    end
                end
                Q_WDATA: begin
                    if (w_sclkRise) begin
                        if (!r_wrHalf) begin
                            w_wrHighNext = r_dq;
                            w_wrHalfNext = 1'b1;
                        end else begin
                            w_wdataNext  = {r_wrHigh, r_dq};
                            w_weNext     = 1'b1;
                            w_wrHalfNext = 1'b0;
                        end
                    end
                end
                IGNORE: begin
                    w_stateNext = IGNORE;
                end
                default: begin
                    w_stateNext = SPI_IDLE;
                end
            endcase
        end
    end

    // Output enable drops in the very cycle the registered csn goes high.
    assign bus.o_psram_dq  = r_dqOut;
    assign bus.o_psram_oe  = r_oe & ~r_csn;
    assign bus.o_mem_addr  = r_addr;
    assign bus.o_mem_we    = r_we;
    assign bus.o_mem_re    = r_re;
    assign bus.o_mem_wdata = r_wdata;
    assign bus.o_quad      = r_quad;
    assign bus.o_active    = ~r_csn & (r_state != SPI_IDLE) & (r_state != Q_IDLE);
endmodule

// File: tb/tb_psram_responder.sv
// Scoreboard bench for psram_responder: stimulus pushes expected writes and read
// nibbles into queues, independent monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_psram_responder;
    typedef struct {
        logic [23:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   strobeCount = 0;

    wr_t        wrQ[$];
    logic [3:0] nibQ[$];
    logic [7:0] mem [logic [23:0]];

    psram_responder_if bus ();

    psram_responder #(.WAIT_CYCLES(6)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Backing memory answers one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.o_mem_re) begin
            bus.i_mem_rdata <= mem.exists(bus.o_mem_addr) ? mem[bus.o_mem_addr] : 8'h00;
        end
    end

    // Write monitor: every write strobe must match the head of the write queue.
    always @(negedge clk) begin
        wr_t exp;
        if (bus.o_mem_we || bus.o_mem_re) strobeCount++;
        if (bus.o_mem_we && bus.o_mem_re) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL strobeOverlap: we and re both high at addr 0x%06h", bus.o_mem_addr);
        end
        if (bus.o_mem_we) begin
            mem[bus.o_mem_addr] = bus.o_mem_wdata;
            vectors++;
            if (wrQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL memWrite: unexpected write 0x%02h at 0x%06h, expected none",
                         bus.o_mem_wdata, bus.o_mem_addr);
            end else begin
                exp = wrQ.pop_front();
                if (bus.o_mem_addr !== exp.addr || bus.o_mem_wdata !== exp.data) begin
                    miscompares++;
                    $display("[TB] FAIL memWrite: got 0x%02h at 0x%06h, expected 0x%02h at 0x%06h",
                             bus.o_mem_wdata, bus.o_mem_addr, exp.data, exp.addr);
                end
            end
        end
    end

    // Read monitor: the controller samples dq on its own sclk rise while oe is high.
    always @(posedge bus.i_psram_sclk) begin
        logic [3:0] expNib;
        if (bus.o_psram_oe) begin
            vectors++;
            if (nibQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL readNibble: unexpected nibble 0x%0h, expected none", bus.o_psram_dq);
            end else begin
                expNib = nibQ.pop_front();
                if (bus.o_psram_dq !== expNib) begin
                    miscompares++;
                    $display("[TB] FAIL readNibble: got 0x%0h, expected 0x%0h", bus.o_psram_dq, expNib);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One sclk period: dq set up while sclk is low, sampled on the rise.
    task automatic applyStimulus(input logic [3:0] dq);
        bus.i_psram_dq   = dq;
        bus.i_psram_sclk = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_psram_sclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic csnLow();
        bus.i_psram_csn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic csnHigh();
        bus.i_psram_sclk = 1'b0;
        repeat (3) @(negedge clk);
        bus.i_psram_csn = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic sendSpiByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) applyStimulus({3'b000, b[i]});
    endtask

    task automatic sendQuadByte(input logic [7:0] b);
        applyStimulus(b[7:4]);
        applyStimulus(b[3:0]);
    endtask

    task automatic sendAddr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) applyStimulus(a[i*4 +: 4]);
    endtask

    task automatic expectWrite(input logic [23:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wrQ.push_back(w);
    endtask

    initial begin
        int strobesBefore;
        bus.i_psram_csn  = 1'b1;
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_dq   = 4'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("rstOe",     {31'd0, bus.o_psram_oe}, 32'd0);
        checkOutput("rstDq",     {28'd0, bus.o_psram_dq}, 32'd0);
        checkOutput("rstQuad",   {31'd0, bus.o_quad},     32'd0);
        checkOutput("rstActive", {31'd0, bus.o_active},   32'd0);
        checkOutput("rstWe",     {31'd0, bus.o_mem_we},   32'd0);
        checkOutput("rstRe",     {31'd0, bus.o_mem_re},   32'd0);
        checkOutput("rstAddr",   {8'd0, bus.o_mem_addr},  32'd0);
        checkOutput("rstWdata",  {24'd0, bus.o_mem_wdata}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Unknown SPI command leaves SPI mode untouched.
        csnLow();
        sendSpiByte(8'h9F);
        csnHigh();
        checkOutput("spiOtherQuad", {31'd0, bus.o_quad}, 32'd0);

        // SPI 0x35 enters quad mode without touching memory.
        strobesBefore = strobeCount;
        csnLow();
        checkOutput("spiActive", {31'd0, bus.o_active}, 32'd1);
        sendSpiByte(8'h35);
        csnHigh();
        checkOutput("spiQuad",     {31'd0, bus.o_quad},   32'd1);
        checkOutput("spiIdle",     {31'd0, bus.o_active}, 32'd0);
        checkOutput("spiNoStrobe", strobeCount - strobesBefore, 32'd0);

        // Quad write burst of two bytes.
        expectWrite(24'h001234, 8'hA5);
        expectWrite(24'h001235, 8'h5A);
        csnLow();
        sendQuadByte(8'h38);
        sendAddr(24'h001234);
        sendQuadByte(8'hA5);
        sendQuadByte(8'h5A);
        csnHigh();
        checkOutput("wrDrained", wrQ.size(), 32'd0);

        // Quad read of the bytes just written, plus the prefetched neighbour.
        nibQ.push_back(4'hA);
        nibQ.push_back(4'h5);
        nibQ.push_back(4'h5);
        nibQ.push_back(4'hA);
        csnLow();
        sendQuadByte(8'hEB);
        sendAddr(24'h001234);
        repeat (6) applyStimulus(4'h0);
        checkOutput("rdOeWait", {31'd0, bus.o_psram_oe}, 32'd0);
        repeat (4) applyStimulus(4'h0);
        csnHigh();
        checkOutput("rdOeEnd",  {31'd0, bus.o_psram_oe}, 32'd0);
        checkOutput("rdDrained", nibQ.size(), 32'd0);

        // Address wraps from the top of the 24-bit space.
        expectWrite(24'hFFFFFF, 8'h11);
        expectWrite(24'h000000, 8'h22);
        csnLow();
        sendQuadByte(8'h38);
        sendAddr(24'hFFFFFF);
        sendQuadByte(8'h11);
        sendQuadByte(8'h22);
        csnHigh();
        checkOutput("wrapDrained", wrQ.size(), 32'd0);

        // Half a data byte then csn high: nothing written, next command clean.
        csnLow();
        sendQuadByte(8'h38);
        sendAddr(24'h000100);
        applyStimulus(4'h7);
        csnHigh();
        expectWrite(24'h000200, 8'h3C);
        csnLow();
        sendQuadByte(8'h38);
        sendAddr(24'h000200);
        sendQuadByte(8'h3C);
        csnHigh();
        checkOutput("partialDrained", wrQ.size(), 32'd0);

        // Quad exit, then back into quad mode over SPI.
        csnLow();
        sendQuadByte(8'hF5);
        csnHigh();
        checkOutput("exitQuad", {31'd0, bus.o_quad}, 32'd0);
        csnLow();
        sendSpiByte(8'h35);
        csnHigh();
        checkOutput("reenterQuad", {31'd0, bus.o_quad}, 32'd1);

        // Reset in the middle of read data.
        nibQ.push_back(4'hA);
        nibQ.push_back(4'h5);
        csnLow();
        sendQuadByte(8'hEB);
        sendAddr(24'h001234);
        repeat (6) applyStimulus(4'h0);
        repeat (2) applyStimulus(4'h0);
        bus.i_psram_sclk = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("oeBeforeRst", {31'd0, bus.o_psram_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstMidOe",   {31'd0, bus.o_psram_oe}, 32'd0);
        checkOutput("rstMidQuad", {31'd0, bus.o_quad},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) applyStimulus(4'h0);
        checkOutput("rstNoResume", {31'd0, bus.o_active}, 32'd0);
        csnHigh();

        // Responder accepts a fresh transaction after reset.
        csnLow();
        sendSpiByte(8'h35);
        csnHigh();
        checkOutput("postRstQuad", {31'd0, bus.o_quad}, 32'd1);
        checkOutput("finalRdQ", nibQ.size(), 32'd0);
        checkOutput("finalWrQ", wrQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/psram_responder.md
PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 6: sclk cycles between last address nibble and first read data nibble.
REQ-002 Port i_clk  input  1  system clock; all logic on rising edge; i_psram_sclk at most i_clk/2.
REQ-003 Port i_rst  input  1  reset, synchronous, active-high.
REQ-004 Port i_psram_csn  input  1  chip select from controller, active-low.
REQ-005 Port i_psram_sclk  input  1  serial clock from controller, oversampled by i_clk.
REQ-006 Port i_psram_dq  input  4  data from controller; SPI mode uses bit 0 only.
REQ-007 Port o_psram_dq  output  4  read data nibble to controller.
REQ-008 Port o_psram_oe  output  1  high while responder drives o_psram_dq.
REQ-009 Port o_mem_addr  output  24  backing-memory byte address.
REQ-010 Port o_mem_we  output  1  one-cycle write strobe.
REQ-011 Port o_mem_re  output  1  one-cycle read strobe.
REQ-012 Port o_mem_wdata  output  8  write byte.
REQ-013 Port i_mem_rdata  input  8  read byte, valid exactly one i_clk after o_mem_re.
REQ-014 Port o_quad  output  1  high when in quad mode.
REQ-015 Port o_active  output  1  high while a transaction is in progress (csn low, state not idle).

Function
REQ-016 sclk and csn registered once; sclk rise = prev 0, cur 1; sclk fall = prev 1, cur 0; dq sampled on the same registered stage.
REQ-017 States: SPI_IDLE, SPI_CMD, Q_IDLE, Q_CMD, Q_ADDR, Q_WAIT, Q_RDATA, Q_WDATA, IGNORE.
REQ-018 SPI_IDLE/Q_IDLE -> SPI_CMD/Q_CMD on registered csn falling edge.
REQ-019 SPI_CMD shifts dq[0] MSB-first on 8 sclk rises; 0x35 sets quad flag; any other command -> IGNORE; after 8th bit -> IGNORE until csn rises.
REQ-020 Q_CMD takes 2 nibbles, high first: 0xEB -> Q_ADDR (read), 0x38 -> Q_ADDR (write), 0xF5 clears quad flag then IGNORE, other -> IGNORE.
REQ-021 Q_ADDR takes 6 nibbles MSB-first into 24-bit address; read -> Q_WAIT, write -> Q_WDATA.
REQ-022 Read: o_mem_re pulses one i_clk after the 6th address nibble rise; returned byte latched into read buffer.
REQ-023 Q_WAIT counts WAIT_CYCLES sclk rises; on the fall following the last wait rise, high nibble driven, o_psram_oe set, -> Q_RDATA.
REQ-024 Q_RDATA: each sclk fall advances one nibble (high, low, next high...); when high nibble is driven, o_mem_re pulses for address+1 (prefetch), buffer updated before low nibble completes.
REQ-025 Q_WDATA: nibbles sampled on sclk rise, high first; after low nibble, o_mem_we pulses one i_clk with current address and byte, address increments.
REQ-026 Address increments by one per byte, modulo 2^24 (0xFFFFFF wraps to 0x000000).
REQ-027 Bursts unlimited in length; terminated only by csn rising.
REQ-028 csn rising in any state: o_psram_oe cleared same cycle, partial write byte discarded, -> Q_IDLE if quad flag else SPI_IDLE.
REQ-029 o_mem_we and o_mem_re never asserted in the same cycle; never asserted while csn high.
REQ-030 sclk edges while csn high ignored.

Reset
REQ-031 On i_rst high at an i_clk rise: state SPI_IDLE, quad flag 0, o_psram_oe 0, o_psram_dq 0, o_mem_we 0, o_mem_re 0, o_mem_addr 0, o_mem_wdata 0, o_active 0.
REQ-032 i_rst mid-transaction aborts the transaction; no pending write completes; responder waits for the next csn fall after reset release.

Verification
REQ-033 SPI 0x35 on dq[0] -> o_quad 1 after csn rise; no memory strobes.
REQ-034 Quad 0x38, addr 0x001234, data 0xA5,0x5A -> o_mem_we at 0x001234=0xA5, 0x001235=0x5A.
REQ-035 Quad 0xEB, addr 0x001234, memory 0xA5 -> after 6 wait cycles dq nibbles 0xA then 0x5, oe high only during data.
REQ-036 Write burst at 0xFFFFFF of 2 bytes -> writes at 0xFFFFFF then 0x000000.
REQ-037 csn raised after 1 nibble of write data -> no o_mem_we; next command parsed normally.
REQ-038 Quad 0xF5 -> o_quad 0; i_rst during read data -> oe 0, o_quad 0 next cycle.
